// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: FSM states, digit count, segment patterns and pin-polarity helpers
package seven_seg_pkg;
  localparam int NUM_DIGITS = 4;
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_t;
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  function automatic logic [7:0] norm_seg(input logic [7:0] v, input bit active_low);
    return active_low ? ~v : v;
  endfunction
  function automatic logic [NUM_DIGITS-1:0] norm_dig(input logic [NUM_DIGITS-1:0] v, input bit active_low);
    return active_low ? ~v : v;
  endfunction
endpackage

// File: rtl/seven_seg_pattern_decode.sv
// seven_seg_pattern_decode: gfedcba segment pattern -> hex nibble plus recognised flag
module seven_seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] pat,
  output logic       recognised,
  output logic [3:0] nibble
);
  // look the pattern up in the table; unknown patterns (incl. blank) give nibble 0
  always_comb begin
    recognised = 1'b0;
    nibble = 4'h0;
    for (int i = 0; i < 16; i++)
      if (pat == SEG_TABLE[i]) begin
        recognised = 1'b1;
        nibble = 4'(i);
      end
  end
endmodule

// File: rtl/seven_seg_scan_decoder.sv
// seven_seg_scan_decoder: samples a scanned 4-digit display and rebuilds the frame; SEVEN_SEG_DEC_GLITCH_CNT_EN adds glitch_cnt
module seven_seg_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int SETTLE_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES   = 65535,
  parameter bit SEG_ACTIVE_LOW   = 1'b1,
  parameter bit DIGIT_ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  y,
  input  logic        digit1,
  input  logic        digit2,
  input  logic        digit3,
  input  logic        digit4,
  output logic [15:0] value,
  output logic [3:0]  dp,
  output logic        valid,
  output logic        digit_err,
`ifdef SEVEN_SEG_DEC_GLITCH_CNT_EN
  output logic [7:0]  glitch_cnt,
`endif
  output logic        stale
);
  localparam int SW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [11:0] s1, s2;
  logic [7:0] seg, seg_ref;
  logic [NUM_DIGITS-1:0] dig, seen, dp_sh;
  logic [1:0] sel_idx, idx;
  logic sel_ok, changed, restart, recognised, frame_err, pend;
  logic [3:0] nibble;
  logic [NUM_DIGITS-1:0][3:0] shadow;
  logic [SW-1:0] cnt;
  logic [TW-1:0] tcnt;
  state_t state;
  assign seg = norm_seg(s2[7:0], SEG_ACTIVE_LOW);
  assign dig = norm_dig(s2[11:8], DIGIT_ACTIVE_LOW);
  assign sel_ok = $onehot(dig);
  assign changed = !sel_ok || sel_idx != idx || seg != seg_ref;
  assign restart = state == SETTLE && changed;
  assign stale = tcnt == TW'(TIMEOUT_CYCLES);
  // bit index of the single selected digit (digit1 maps to slot 3)
  always_comb begin
    sel_idx = 2'd0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (dig[i]) sel_idx = 2'(i);
  end
  seven_seg_pattern_decode u_dec (.pat(seg_ref[6:0]), .recognised(recognised), .nibble(nibble));
  // two-flop synchroniser for the asynchronous display pins
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {digit1, digit2, digit3, digit4, y};
      s2 <= s1;
    end
  // slot qualification FSM, shadow frame assembly and frame publication
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      seg_ref <= '0;
      shadow <= '0;
      dp_sh <= '0;
      seen <= '0;
      frame_err <= 1'b0;
      pend <= 1'b0;
      value <= '0;
      dp <= '0;
      valid <= 1'b0;
      digit_err <= 1'b0;
    end else begin
      valid <= pend;
      pend <= 1'b0;
      if (pend) begin
        value <= shadow;
        dp <= dp_sh;
        digit_err <= frame_err;
        seen <= '0;
        frame_err <= 1'b0;
      end
      case (state)
        IDLE:
          if (sel_ok) begin
            idx <= sel_idx;
            cnt <= '0;
            seg_ref <= seg;
            state <= SETTLE;
          end
        SETTLE:
          if (changed) begin
            idx <= sel_idx;
            cnt <= '0;
            seg_ref <= seg;
            state <= sel_ok ? SETTLE : IDLE;
          end else if (cnt == SW'(SETTLE_CYCLES - 1)) state <= CAPTURE;
          else cnt <= cnt + 1'b1;
        CAPTURE: begin
          shadow[idx] <= nibble;
          dp_sh[idx] <= seg_ref[7];
          seen <= seen | (4'b1 << idx);
          frame_err <= frame_err | !recognised;
          pend <= (seen | (4'b1 << idx)) == 4'hF;
          state <= HOLD;
        end
        default:
          if (!sel_ok) state <= IDLE;
          else if (sel_idx != idx) begin
            idx <= sel_idx;
            cnt <= '0;
            seg_ref <= seg;
            state <= SETTLE;
          end
      endcase
    end
  // saturating count of cycles since the last published frame
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tcnt <= '0;
    else if (pend) tcnt <= '0;
    else if (!stale) tcnt <= tcnt + 1'b1;
`ifdef SEVEN_SEG_DEC_GLITCH_CNT_EN
  // saturating count of settle restarts caused by unstable inputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) glitch_cnt <= '0;
    else if (restart && glitch_cnt != 8'hFF) glitch_cnt <= glitch_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// tb_seven_seg_scan_decoder: directed scans of a 4-digit display with hand-computed frames
module tb_seven_seg_scan_decoder;
  localparam logic [3:0] D1 = 4'b1000, D2 = 4'b0100, D3 = 4'b0010, D4 = 4'b0001;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] y = 8'hFF;
  logic digit1 = 1'b0, digit2 = 1'b0, digit3 = 1'b0, digit4 = 1'b0;
  logic [15:0] value;
  logic [3:0] dp;
  logic valid, digit_err, stale;
`ifdef SEVEN_SEG_DEC_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif
  int vectors = 0, miscompares = 0, vcount = 0, v0;
  seven_seg_scan_decoder #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(100), .SEG_ACTIVE_LOW(1'b1), .DIGIT_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .y(y),
    .digit1(digit1), .digit2(digit2), .digit3(digit3), .digit4(digit4),
    .value(value), .dp(dp), .valid(valid), .digit_err(digit_err),
`ifdef SEVEN_SEG_DEC_GLITCH_CNT_EN
    .glitch_cnt(glitch_cnt),
`endif
    .stale(stale)
  );
  always #5 clk = ~clk;
  // counts valid pulses, sampled away from the active edge
  always @(negedge clk) if (valid === 1'b1) vcount++;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [3:0] d, input logic [7:0] segs, input int n);
    {digit1, digit2, digit3, digit4} = d;
    y = ~segs;
    repeat (n) @(negedge clk);
  endtask
  task automatic scan(input logic [3:0] d, input logic [6:0] pat, input logic pt);
    drive(d, {pt, pat}, 10);
  endtask
  task automatic frame_check(input string tag, input int base, input logic [15:0] ev, input logic [3:0] edp, input logic eerr);
    check({tag, "_valid_count"}, vcount, base + 1);
    check({tag, "_value"}, value, ev);
    check({tag, "_dp"}, dp, edp);
    check({tag, "_digit_err"}, digit_err, eerr);
    check({tag, "_stale"}, stale, 1'b0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_value", value, 16'h0);
    check("rst_dp", dp, 4'h0);
    check("rst_valid", valid, 1'b0);
    check("rst_digit_err", digit_err, 1'b0);
    check("rst_stale", stale, 1'b0);
    rst_n = 1'b1;
    repeat (99) @(posedge clk);
    #1 check("stale_at_99", stale, 1'b0);
    @(posedge clk);
    #1 check("stale_at_100", stale, 1'b1);
    @(negedge clk);
    v0 = vcount;
    scan(D1, 7'h06, 1'b0); scan(D2, 7'h5B, 1'b0); scan(D3, 7'h4F, 1'b0); scan(D4, 7'h66, 1'b0);
    drive(4'h0, 8'h00, 5);
    frame_check("f1234", v0, 16'h1234, 4'b0000, 1'b0);
    v0 = vcount;
    scan(D1, 7'h77, 1'b1); scan(D2, 7'h7C, 1'b0); scan(D3, 7'h39, 1'b1); scan(D4, 7'h5E, 1'b0);
    drive(4'h0, 8'h00, 5);
    frame_check("fABCD", v0, 16'hABCD, 4'b1010, 1'b0);
    v0 = vcount;
    scan(D1, 7'h06, 1'b0); scan(D2, 7'h49, 1'b0); scan(D3, 7'h4F, 1'b0); scan(D4, 7'h66, 1'b0);
    drive(4'h0, 8'h00, 5);
    frame_check("bad_pat", v0, 16'h1034, 4'b0000, 1'b1);
    v0 = vcount;
    scan(D1, 7'h6D, 1'b0); scan(D2, 7'h7D, 1'b0); scan(D3, 7'h07, 1'b0); scan(D4, 7'h7F, 1'b0);
    drive(4'h0, 8'h00, 5);
    frame_check("clean_after_bad", v0, 16'h5678, 4'b0000, 1'b0);
    v0 = vcount;
    scan(D1, 7'h6F, 1'b0); scan(D2, 7'h79, 1'b0); scan(D1, 7'h71, 1'b0); scan(D3, 7'h3F, 1'b0); scan(D4, 7'h7F, 1'b0);
    drive(4'h0, 8'h00, 5);
    frame_check("overwrite", v0, 16'hFE08, 4'b0000, 1'b0);
    v0 = vcount;
    for (int k = 0; k < 20; k++) drive(D2, k[0] ? 8'h06 : 8'h5B, 2);
    drive(4'h0, 8'h00, 5);
`ifdef SEVEN_SEG_DEC_GLITCH_CNT_EN
    check("glitch_cnt_nonzero", glitch_cnt != 8'h0, 1'b1);
`endif
    scan(D1, 7'h07, 1'b0); scan(D3, 7'h39, 1'b0); scan(D4, 7'h79, 1'b0);
    drive(4'h0, 8'h00, 5);
    check("glitch_no_capture", vcount, v0);
    scan(D2, 7'h7D, 1'b0);
    drive(4'h0, 8'h00, 5);
    frame_check("after_glitch", v0, 16'h76CE, 4'b0000, 1'b0);
    v0 = vcount;
    drive(D1 | D3, 8'h7F, 20);
    drive(4'h0, 8'h00, 5);
    scan(D2, 7'h06, 1'b0); scan(D4, 7'h5B, 1'b0);
    drive(4'h0, 8'h00, 5);
    check("multi_sel_no_capture", vcount, v0);
    scan(D1, 7'h6F, 1'b0); scan(D3, 7'h77, 1'b0);
    drive(4'h0, 8'h00, 5);
    frame_check("after_multi_sel", v0, 16'h91A2, 4'b0000, 1'b0);
    v0 = vcount;
    scan(D1, 7'h4F, 1'b0); scan(D2, 7'h66, 1'b0); scan(D3, 7'h6D, 1'b0);
    drive(4'h0, 8'h00, 5);
    check("three_digits_no_valid", vcount, v0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset_value", value, 16'h0);
    check("midreset_valid", valid, 1'b0);
    scan(D4, 7'h7D, 1'b0);
    drive(4'h0, 8'h00, 5);
    check("midreset_partial_no_valid", vcount, v0);
    check("midreset_value_held", value, 16'h0);
    scan(D1, 7'h4F, 1'b0); scan(D2, 7'h66, 1'b0); scan(D3, 7'h6D, 1'b0);
    drive(4'h0, 8'h00, 5);
    frame_check("after_midreset", v0, 16'h3456, 4'b0000, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
